// File: rtl/timekeeper_core.sv
// timekeeper_core
//   Parametrised time-of-day counter (seconds / minutes / hours) that derives
//   its own count step from the system clock via a prescaler. Counts up or
//   down with full carry/borrow, has a button-driven set-mode FSM, a parallel
//   preset load, and emits one-cycle tick / day_wrap / alarm pulses.
//
//   Optional feature: define TIMEKEEPER_ALARM_EN to build the alarm compare.
//   Without it, alarm is tied low and alarm_arm/alarm_h/alarm_m are ignored.
//
// Parameters
//   TICK_DIV  system clocks per count step (>= 1)
//   HOURS     hour modulus (2..32)
//   HW        hours field width, 2^HW >= HOURS
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   run, dir                   count enable (RUN state only), 0 = up / 1 = down
//   mode_btn, inc_btn, dec_btn single-cycle button pulses for set mode
//   load, load_h/m/s           parallel preset (saturated to legal range)
//   alarm_arm, alarm_h/m       alarm enable and compare time
//   seconds, minutes, hours    current time
//   state                      0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   tick, day_wrap, alarm      one-cycle pulses, registered on the step edge
//
// Handshake: there is no valid/ready flow here; every button and load input
// is a single-cycle strobe sampled on the rising edge, and every pulse output
// is high for exactly one cycle following the edge that caused it.
module timekeeper_core #(
    parameter int TICK_DIV = 50000000,
    parameter int HOURS    = 24,
    parameter int HW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          dir,
    input  logic          mode_btn,
    input  logic          inc_btn,
    input  logic          dec_btn,
    input  logic          load,
    input  logic [HW-1:0] load_h,
    input  logic [5:0]    load_m,
    input  logic [5:0]    load_s,
    input  logic          alarm_arm,
    input  logic [HW-1:0] alarm_h,
    input  logic [5:0]    alarm_m,
    output logic [5:0]    seconds,
    output logic [5:0]    minutes,
    output logic [HW-1:0] hours,
    output logic [1:0]    state,
    output logic          tick,
    output logic          day_wrap,
    output logic          alarm
);

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]   HOUR_MAX = HW'(HOURS - 1);
    localparam logic [5:0]      MS_MAX   = 6'd59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [HW-1:0] hr_q, hr_d;
    logic          tick_q, wrap_q, alarm_q;
    logic          tick_d, wrap_d, alarm_d;
    logic          step;

    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v == MS_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] ms_dec(input logic [5:0] v);
        return (v == 6'd0) ? MS_MAX : v - 6'd1;
    endfunction

    function automatic logic [HW-1:0] hr_inc(input logic [HW-1:0] v);
        return (v == HOUR_MAX) ? '0 : v + HW'(1);
    endfunction

    function automatic logic [HW-1:0] hr_dec(input logic [HW-1:0] v);
        return (v == '0) ? HOUR_MAX : v - HW'(1);
    endfunction

    // Next-state / next-field logic; the if-chain order is the priority
    // load > mode_btn > inc/dec > count step.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        step    = 1'b0;

        if (load) begin
            hr_d    = (load_h > HOUR_MAX) ? HOUR_MAX : load_h;
            min_d   = (load_m > MS_MAX)   ? MS_MAX   : load_m;
            sec_d   = (load_s > MS_MAX)   ? MS_MAX   : load_s;
            presc_d = '0;
        end else if (mode_btn) begin
            case (state_q)
                RUN: begin
                    state_d = SET_H;
                    presc_d = '0;
                end
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end else if (state_q != RUN) begin
            // Both buttons together cancel out; edits never carry.
            if (inc_btn != dec_btn) begin
                case (state_q)
                    SET_H:   hr_d  = inc_btn ? hr_inc(hr_q)  : hr_dec(hr_q);
                    SET_M:   min_d = inc_btn ? ms_inc(min_q) : ms_dec(min_q);
                    SET_S:   sec_d = inc_btn ? ms_inc(sec_q) : ms_dec(sec_q);
                    default: ;
                endcase
            end
        end else if (run) begin
            if (presc_q == PRESC_TC) begin
                presc_d = '0;
                step    = 1'b1;
                tick_d  = 1'b1;
                if (!dir) begin
                    sec_d = ms_inc(sec_q);
                    if (sec_q == MS_MAX) begin
                        min_d = ms_inc(min_q);
                        if (min_q == MS_MAX) begin
                            hr_d   = hr_inc(hr_q);
                            wrap_d = (hr_q == HOUR_MAX);
                        end
                    end
                end else begin
                    sec_d = ms_dec(sec_q);
                    if (sec_q == 6'd0) begin
                        min_d = ms_dec(min_q);
                        if (min_q == 6'd0) begin
                            hr_d   = hr_dec(hr_q);
                            wrap_d = (hr_q == '0);
                        end
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

`ifdef TIMEKEEPER_ALARM_EN
    // Only a RUN step landing exactly on alarm_h:alarm_m:00 fires.
    assign alarm_d = step && alarm_arm && (hr_d == alarm_h) &&
                     (min_d == alarm_m) && (sec_d == 6'd0);
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alarm_arm, alarm_h, alarm_m, step};
    assign alarm_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            alarm_q <= alarm_d;
        end
    end

    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign hours    = hr_q;
    assign state    = state_q;
    assign tick     = tick_q;
    assign day_wrap = wrap_q;
    assign alarm    = alarm_q;

endmodule
